// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use stalls, redirects,
// data-memory wait holds, debug halt/drain handshake and saturating perf counters.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             MemReq_mem,
  input  logic             MemReady,
  input  logic             HaltReq,
  input  logic             ClrCnt,
  output logic             PCWrite,
  output logic             IFWrite,
  output logic             IDFlush,
  output logic             EXFlush,
  output logic             PipeHold,
  output logic             Redirect,
  output logic             Stall,
  output logic             HaltAck,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] WaitCnt
);

  localparam int unsigned DW = 4;
  localparam int unsigned TW = 8;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LIM    = TW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             halt_ack_q, halt_ack_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_wait;
  logic load_use;

  assign mem_wait = MemReq_mem & ~MemReady;
  assign load_use = MemRead_ex & (rdAddr_ex != 5'd0) &
                    ((rs1Used_id & (rdAddr_ex == rs1Addr_id)) |
                     (rs2Used_id & (rdAddr_ex == rs2Addr_id)));

  // Control outputs and next state; priority reset > wait > halt > load-use > redirect
  always_comb begin
    PCWrite  = 1'b0;
    IFWrite  = 1'b0;
    IDFlush  = 1'b0;
    EXFlush  = 1'b0;
    PipeHold = 1'b0;
    Redirect = 1'b0;
    Stall    = 1'b0;
    state_d  = state_q;
    drain_d  = drain_q;
    if (!rst_n) begin
      IDFlush = 1'b1;
      EXFlush = 1'b1;
    end else if (mem_wait) begin
      PipeHold = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (HaltReq) begin
            EXFlush = 1'b1;
            if (DRAIN_CYCLES <= 32'd1) begin
              state_d = ST_HALTED;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_INIT;
            end
          end else if (load_use) begin
            Stall   = 1'b1;
            EXFlush = 1'b1;
          end else if (Branch | Jump) begin
            Redirect = 1'b1;
            PCWrite  = 1'b1;
            IFWrite  = 1'b1;
            IDFlush  = 1'b1;
          end else begin
            PCWrite = 1'b1;
            IFWrite = 1'b1;
          end
        end
        ST_DRAIN: begin
          EXFlush = 1'b1;
          if (!HaltReq) begin
            state_d = ST_RUN;
            drain_d = '0;
          end else if (drain_q <= DW'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        ST_HALTED: begin
          EXFlush = 1'b1;
          if (!HaltReq) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  // Wait timeout tracking and registered status
  always_comb begin
    tmo_d      = '0;
    mem_err_d  = mem_err_q;
    halt_ack_d = (state_d == ST_HALTED);
    if (mem_wait) begin
      tmo_d = (tmo_q >= TMO_LIM) ? tmo_q : tmo_q + TW'(1);
      if (tmo_d >= TMO_LIM) begin
        mem_err_d = 1'b1;
      end
    end
  end

  // Saturating performance counters, clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (ClrCnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      wait_cnt_d  = '0;
    end else begin
      if (Stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (Redirect && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (mem_wait && wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      tmo_q       <= '0;
      halt_ack_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      tmo_q       <= tmo_d;
      halt_ack_q  <= halt_ack_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign HaltAck  = halt_ack_q;
  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign WaitCnt  = wait_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  localparam int unsigned DRAIN = 3;
  localparam int unsigned TMO   = 64;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          MemRead_ex;
  logic [4:0]    rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic          rs1Used_id, rs2Used_id, Branch, Jump;
  logic          MemReq_mem, MemReady, HaltReq, ClrCnt;
  logic          PCWrite, IFWrite, IDFlush, EXFlush, PipeHold, Redirect, Stall;
  logic          HaltAck, MemErr;
  logic [CW-1:0] StallCnt, FlushCnt, WaitCnt;

  int checks = 0;
  int errors = 0;

  // Model: halt progress counted as bubble cycles since halt entry
  bit m_in_halt;
  int m_bub, m_wrun;
  bit m_err;
  int m_sc, m_fc, m_wc;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rs1Used_id(rs1Used_id),
    .rs2Used_id(rs2Used_id), .Branch(Branch), .Jump(Jump), .MemReq_mem(MemReq_mem),
    .MemReady(MemReady), .HaltReq(HaltReq), .ClrCnt(ClrCnt), .PCWrite(PCWrite),
    .IFWrite(IFWrite), .IDFlush(IDFlush), .EXFlush(EXFlush), .PipeHold(PipeHold),
    .Redirect(Redirect), .Stall(Stall), .HaltAck(HaltAck), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .WaitCnt(WaitCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    rs1Used_id = 0; rs2Used_id = 0; Branch = 0; Jump = 0;
    MemReq_mem = 0; MemReady = 1; HaltReq = 0; ClrCnt = 0;
  endtask

  task automatic m_reset();
    m_in_halt = 0; m_bub = 0; m_wrun = 0; m_err = 0;
    m_sc = 0; m_fc = 0; m_wc = 0;
  endtask

  // One cycle: compare every output with the model, clock, advance the model
  task automatic step();
    bit mw, lu;
    bit pc, ifw, idf, exf, hold, red, stl;
    #2;
    mw = MemReq_mem && !MemReady;
    lu = MemRead_ex && rdAddr_ex != 0 &&
         ((rs1Used_id && rdAddr_ex == rs1Addr_id) || (rs2Used_id && rdAddr_ex == rs2Addr_id));
    {pc, ifw, idf, exf, hold, red, stl} = '0;
    if (mw) hold = 1;
    else if (m_in_halt || HaltReq) exf = 1;
    else if (lu) begin stl = 1; exf = 1; end
    else if (Branch || Jump) begin red = 1; pc = 1; ifw = 1; idf = 1; end
    else begin pc = 1; ifw = 1; end
    chk("PCWrite", int'(PCWrite), int'(pc));
    chk("IFWrite", int'(IFWrite), int'(ifw));
    chk("IDFlush", int'(IDFlush), int'(idf));
    chk("EXFlush", int'(EXFlush), int'(exf));
    chk("PipeHold", int'(PipeHold), int'(hold));
    chk("Redirect", int'(Redirect), int'(red));
    chk("Stall", int'(Stall), int'(stl));
    chk("HaltAck", int'(HaltAck), int'(m_in_halt && m_bub >= int'(DRAIN)));
    chk("MemErr", int'(MemErr), int'(m_err));
    chk("StallCnt", int'(StallCnt), m_sc);
    chk("FlushCnt", int'(FlushCnt), m_fc);
    chk("WaitCnt", int'(WaitCnt), m_wc);
    @(posedge clk);
    if (mw) begin
      m_wrun++;
      if (m_wrun >= int'(TMO)) m_err = 1;
    end else begin
      m_wrun = 0;
    end
    if (ClrCnt) begin
      m_sc = 0; m_fc = 0; m_wc = 0;
    end else begin
      if (stl && m_sc < CMAX) m_sc++;
      if (red && m_fc < CMAX) m_fc++;
      if (mw && m_wc < CMAX) m_wc++;
    end
    if (!mw) begin
      if (m_in_halt) begin
        if (!HaltReq) begin m_in_halt = 0; m_bub = 0; end
        else if (m_bub < int'(DRAIN)) m_bub++;
      end else if (HaltReq) begin
        m_in_halt = 1; m_bub = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    m_reset();
    #1;
    chk("rst_PCWrite", int'(PCWrite), 0);
    chk("rst_IDFlush", int'(IDFlush), 1);
    chk("rst_EXFlush", int'(EXFlush), 1);
    chk("rst_HaltAck", int'(HaltAck), 0);
    chk("rst_WaitCnt", int'(WaitCnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Load-use beats a same-cycle branch
    MemRead_ex = 1; rdAddr_ex = 5; rs2Addr_id = 5; rs2Used_id = 1; Branch = 1;
    #1;
    chk("lu_Stall", int'(Stall), 1);
    chk("lu_PCWrite", int'(PCWrite), 0);
    chk("lu_EXFlush", int'(EXFlush), 1);
    chk("lu_Redirect", int'(Redirect), 0);
    step();
    chk("lu_StallCnt", int'(StallCnt), 1);
    // x0 destination never stalls, so the branch redirects
    rdAddr_ex = 0; rs2Addr_id = 0;
    #1;
    chk("x0_Stall", int'(Stall), 0);
    chk("x0_Redirect", int'(Redirect), 1);
    step();
    clear_inputs();
    Jump = 1;
    step();
    step();
    chk("jmp_FlushCnt", int'(FlushCnt), 3);

    // Memory wait masks a load-use for three cycles
    clear_inputs();
    MemRead_ex = 1; rdAddr_ex = 7; rs1Addr_id = 7; rs1Used_id = 1;
    MemReq_mem = 1; MemReady = 0;
    #1;
    chk("mw_PipeHold", int'(PipeHold), 1);
    chk("mw_Stall", int'(Stall), 0);
    chk("mw_EXFlush", int'(EXFlush), 0);
    for (int i = 0; i < 3; i++) step();
    chk("mw_WaitCnt", int'(WaitCnt), 3);
    MemReady = 1;
    #1;
    chk("mw_resume_Stall", int'(Stall), 1);
    step();

    // Halt with a wait cycle inside the drain
    clear_inputs();
    HaltReq = 1;
    step();
    step();
    MemReq_mem = 1; MemReady = 0;
    #1;
    chk("hd_wait_EXFlush", int'(EXFlush), 0);
    step();
    chk("hd_ack_early", int'(HaltAck), 0);
    MemReady = 1;
    step();
    chk("hd_ack", int'(HaltAck), 1);
    HaltReq = 0;
    #1;
    chk("hd_leave_PCWrite", int'(PCWrite), 0);
    step();
    chk("hd_ack_drop", int'(HaltAck), 0);
    #1;
    chk("hd_run_PCWrite", int'(PCWrite), 1);
    step();

    // Async reset while draining
    HaltReq = 1;
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    chk("ar_PCWrite", int'(PCWrite), 0);
    chk("ar_IDFlush", int'(IDFlush), 1);
    chk("ar_HaltAck", int'(HaltAck), 0);
    chk("ar_FlushCnt", int'(FlushCnt), 0);
    m_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("ar_run_PCWrite", int'(PCWrite), 1);
    step();

    // Timeout and counter saturation
    MemReq_mem = 1; MemReady = 0;
    for (int i = 0; i < int'(TMO) - 1; i++) step();
    chk("to_MemErr_early", int'(MemErr), 0);
    step();
    chk("to_MemErr", int'(MemErr), 1);
    chk("to_WaitCnt_sat", int'(WaitCnt), CMAX);
    MemReady = 1;
    step();
    chk("to_MemErr_sticky", int'(MemErr), 1);
    ClrCnt = 1;
    MemReady = 0;
    step();
    chk("clr_WaitCnt", int'(WaitCnt), 0);
    ClrCnt = 0;

    // Randomized traffic
    clear_inputs();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      MemRead_ex = 1'($urandom_range(0, 1));
      rdAddr_ex  = 5'($urandom_range(0, 3));
      rs1Addr_id = 5'($urandom_range(0, 3));
      rs2Addr_id = 5'($urandom_range(0, 3));
      rs1Used_id = 1'($urandom_range(0, 1));
      rs2Used_id = 1'($urandom_range(0, 1));
      Branch     = ($urandom_range(0, 3) == 0);
      Jump       = ($urandom_range(0, 5) == 0);
      MemReq_mem = 1'($urandom_range(0, 1));
      MemReady   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) HaltReq = ~HaltReq;
      ClrCnt     = ($urandom_range(0, 40) == 0);
      if (n == 2000) begin
        // Long wait run inside random traffic
        MemReq_mem = 1; MemReady = 0;
        for (int k = 0; k < 70; k++) step();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. It replaces the ad-hoc load-use detect in the decode stage and generates all pipeline-register write-enables, bubbles and redirects. It also handles variable-latency data-memory waits, a debug halt/drain handshake, and saturating performance counters. Sits beside the decode stage; its outputs drive the PC, the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
DRAIN_CYCLES, 3, bubble cycles inserted after halt entry before HaltAck (1..15)
MEM_TIMEOUT, 64, consecutive memory-wait cycles that set MemErr (2..255)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
MemRead_ex  in  1  load in EX
rdAddr_ex  in  5  EX destination register
rs1Addr_id  in  5  ID source 1
rs2Addr_id  in  5  ID source 2
rs1Used_id  in  1  ID instruction reads rs1
rs2Used_id  in  1  ID instruction reads rs2
Branch  in  1  taken branch resolved in ID
Jump  in  1  JAL/JALR in ID
MemReq_mem  in  1  load/store in MEM
MemReady  in  1  data memory completes access this cycle
HaltReq  in  1  debug halt request (level)
ClrCnt  in  1  synchronous counter clear
PCWrite  out  1  PC update enable
IFWrite  out  1  IF/ID write enable
IDFlush  out  1  IF/ID loads NOP
EXFlush  out  1  ID/EX loads bubble
PipeHold  out  1  freeze ID/EX, EX/MEM, MEM/WB
Redirect  out  1  PC mux selects JumpAddr
Stall  out  1  effective load-use stall
HaltAck  out  1  core halted (registered)
MemErr  out  1  sticky memory timeout (registered)
StallCnt  out  CNT_W  load-use stall cycles
FlushCnt  out  CNT_W  redirect count
WaitCnt  out  CNT_W  memory-wait cycles

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. While rst_n=0: state RUN, drain counter 0, timeout counter 0, HaltAck 0, MemErr 0, all counters 0; combinational outputs forced PCWrite=0, IFWrite=0, IDFlush=1, EXFlush=1, PipeHold=0, Redirect=0, Stall=0.
- Terms: MemWait = MemReq_mem & ~MemReady. LU = MemRead_ex & (rdAddr_ex!=0) & ((rs1Used_id & rdAddr_ex==rs1Addr_id) | (rs2Used_id & rdAddr_ex==rs2Addr_id)). Register x0 never stalls.
- States: RUN, DRAIN, HALTED. Control outputs are combinational from state plus inputs (zero latency). Priority: reset > MemWait > halt > LU > redirect > normal.
- Any state with MemWait: PipeHold=1, PCWrite=0, IFWrite=0, IDFlush=0, EXFlush=0, Redirect=0, Stall=0. State and drain counter frozen.
- RUN, no MemWait:
  - HaltReq=1: PCWrite=0, IFWrite=0, EXFlush=1, Redirect=0. The ID instruction is retained for re-issue. Go to DRAIN with drain counter = DRAIN_CYCLES-1; if DRAIN_CYCLES=1, go directly to HALTED.
  - else LU: Stall=1, PCWrite=0, IFWrite=0, EXFlush=1, Redirect=0. Branch/Jump are ignored because their operands are stale.
  - else Branch|Jump: Redirect=1, PCWrite=1, IFWrite=1, IDFlush=1.
  - else PCWrite=1, IFWrite=1, all flushes 0.
- DRAIN: outputs as halt entry. HaltReq=0 returns to RUN next cycle (abort). Otherwise the counter decrements each non-MemWait cycle; at 0, go to HALTED.
- HALTED: outputs as halt entry; HaltAck=1 (registered on entry). HaltReq=0 returns to RUN next cycle, with HaltAck=0 in that cycle.
- Timeout counter (8 bit) increments on consecutive MemWait cycles and clears on any non-MemWait cycle. When the count reaches MEM_TIMEOUT, MemErr sets and stays set until reset; the pipeline keeps holding.
- Counters: StallCnt +1 per Stall=1 cycle; FlushCnt +1 per Redirect=1 cycle; WaitCnt +1 per MemWait cycle. Each saturates at all-ones and never wraps. ClrCnt=1 zeroes all three next edge and overrides any same-cycle increment.

Test Plan:
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1, Branch=1 -> Stall=1, PCWrite=0, EXFlush=1, Redirect=0, StallCnt 0->1; the same case with rdAddr_ex=0 -> Stall=0, Redirect=1.
- Redirect: Jump=1, no hazards -> Redirect=1, IDFlush=1, PCWrite=1, FlushCnt +1 per cycle.
- Memory wait: MemReq_mem=1, MemReady=0 for 3 cycles with LU also true -> PipeHold=1, Stall=0, EXFlush=0 for 3 cycles, WaitCnt=3; MemReady=1 -> LU stall resumes.
- Halt: HaltReq rises with DRAIN_CYCLES=3 and a MemWait cycle inside the drain -> EXFlush=1 for 4 cycles, HaltAck=1 on the 4th edge; HaltReq falls -> RUN and PCWrite=1 the next cycle.
- Timeout plus saturation: MemWait held 64 cycles with MEM_TIMEOUT=64 -> MemErr=1 at the 64th edge and stays set after MemReady; with CNT_W=4, 20 wait cycles -> WaitCnt=15; ClrCnt=1 -> all counters 0.
- Async reset mid-DRAIN: rst_n low between edges -> immediately PCWrite=0, IDFlush=1, HaltAck=0; after release -> RUN, PCWrite=1.
